uart_rx_frame: RTL and testbench

UART receive stage for the RISC-V multi-cycle SoC. It sits between the `UART_Rx` pad and the processor's memory-mapped UART registers. It oversamples the asynchronous serial line and deframes 11-bit characters: start bit, 8 data bits LSB first, even parity, and stop bit. It holds each received byte with status flags until the core acknowledges it.

---
 rtl/uart_rx_frame.sv | 177 +++++++++++++++++
 tb/tb_uart_rx_frame.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame.sv
// UART receive deframer: 2-flop synchronizer, start-edge detect, mid-bit
// sampling of start/8 data (LSB first)/even parity/stop, and a holding
// register with ready/error/overrun status that the core acknowledges.
module uart_rx_frame #(
  parameter int CLKS_PER_BIT = 434,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       rx_clear,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       rx_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t           state_reg, state_next;
  logic             sync1_reg, rx_s_reg, rx_d_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       bit_idx_reg;
  logic [7:0]       shift_reg;
  logic             par_bit_reg;
  logic [7:0]       bit_en;

  logic [7:0]       rx_data_reg;
  logic             rx_ready_reg, parity_err_reg, frame_err_reg, overrun_reg;

  // decoded FSM strobes
  logic cnt_clear, data_sample, par_sample, commit;

  // Synchronizer flops reset high so a reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_reg <= 1'b1;
      rx_s_reg  <= 1'b1;
      rx_d_reg  <= 1'b1;
    end else begin
      sync1_reg <= rx;
      rx_s_reg  <= sync1_reg;
      rx_d_reg  <= rx_s_reg;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= S_IDLE;
    else      state_reg <= state_next;
  end

  // Next-state and sample strobes; counter is cleared at every bit boundary.
  always_comb begin
    state_next  = state_reg;
    cnt_clear   = 1'b0;
    data_sample = 1'b0;
    par_sample  = 1'b0;
    commit      = 1'b0;
    case (state_reg)
      S_IDLE: begin
        cnt_clear = 1'b1;
        if (rx_d_reg && !rx_s_reg) state_next = S_START;
      end
      S_START: begin
        if (cnt_reg == CNT_HALF) begin
          cnt_clear  = 1'b1;
          state_next = rx_s_reg ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt_reg == CNT_LAST) begin
          cnt_clear   = 1'b1;
          data_sample = 1'b1;
          if (bit_idx_reg == 3'd7) state_next = S_PARITY;
        end
      end
      S_PARITY: begin
        if (cnt_reg == CNT_LAST) begin
          cnt_clear  = 1'b1;
          par_sample = 1'b1;
          state_next = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_reg == CNT_LAST) begin
          cnt_clear  = 1'b1;
          commit     = 1'b1;
          state_next = rx_s_reg ? S_IDLE : S_BREAK;
        end
      end
      S_BREAK: begin
        cnt_clear = 1'b1;
        if (rx_s_reg) state_next = S_IDLE;
      end
      default: begin
        cnt_clear  = 1'b1;
        state_next = S_IDLE;
      end
    endcase
  end

  // Cycle counter within a bit and data bit index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg     <= '0;
      bit_idx_reg <= 3'd0;
    end else begin
      cnt_reg <= cnt_clear ? '0 : cnt_reg + 1'b1;
      if (state_reg == S_IDLE) bit_idx_reg <= 3'd0;
      else if (data_sample)    bit_idx_reg <= bit_idx_reg + 3'd1;
    end
  end

  // One-hot write enable per data bit, selected by the bit index.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_bit_en
      assign bit_en[gi] = data_sample && (bit_idx_reg == 3'(gi));
    end
  endgenerate

  // Data and parity capture at the mid-bit sample points.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_reg   <= 8'h00;
      par_bit_reg <= 1'b0;
    end else begin
      shift_reg <= (shift_reg & ~bit_en) | ({8{rx_s_reg}} & bit_en);
      if (par_sample) par_bit_reg <= rx_s_reg;
    end
  end

  // Holding register: a commit beats a same-cycle acknowledge, and that
  // acknowledge consumes the old byte so overrun is not raised.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_data_reg    <= 8'h00;
      rx_ready_reg   <= 1'b0;
      parity_err_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      overrun_reg    <= 1'b0;
    end else if (commit) begin
      rx_data_reg    <= shift_reg;
      parity_err_reg <= (^shift_reg) ^ par_bit_reg;
      frame_err_reg  <= ~rx_s_reg;
      overrun_reg    <= rx_clear ? 1'b0 : (overrun_reg | rx_ready_reg);
      rx_ready_reg   <= 1'b1;
    end else if (rx_clear) begin
      rx_ready_reg   <= 1'b0;
      parity_err_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      overrun_reg    <= 1'b0;
    end
  end

  assign rx_data    = rx_data_reg;
  assign rx_ready   = rx_ready_reg;
  assign parity_err = parity_err_reg;
  assign frame_err  = frame_err_reg;
  assign overrun    = overrun_reg;
  assign rx_busy    = (state_reg != S_IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame: table-driven frames, hand-written
// corner sequences and randomized frames against a byte-level model.
`timescale 1ns/1ps
module tb_uart_rx_frame;

  localparam int CPB = 434;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       rx_clear;
  logic [7:0] rx_data;
  logic       rx_ready, parity_err, frame_err, overrun, rx_busy;

  int n_vec = 0;
  int n_err = 0;

  uart_rx_frame dut (
    .clk(clk), .rst(rst), .rx(rx), .rx_clear(rx_clear),
    .rx_data(rx_data), .rx_ready(rx_ready), .parity_err(parity_err),
    .frame_err(frame_err), .overrun(overrun), .rx_busy(rx_busy)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic       clr;
    logic [7:0] exp_data;
    logic       exp_pe;
    logic       exp_fe;
    logic       exp_ov;
  } vec_t;

  vec_t tbl [5];

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b, expected %0b", name, act, exp);
    end
  endtask

  // Drive start, 8 data bits LSB first, parity, stop; line left at stop value.
  task automatic send_bits(input logic [7:0] d, input logic p, input logic s);
    logic [10:0] bits;
    bits = {s, p, d, 1'b0};
    @(posedge clk);
    for (int i = 0; i < 11; i++) begin
      #1 rx = bits[i];
      repeat (CPB) @(posedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    send_bits(d, p, s);
    #1 rx = 1'b1;
    repeat (20) @(posedge clk);
  endtask

  task automatic pulse_clear();
    @(posedge clk);
    #1 rx_clear = 1'b1;
    @(posedge clk);
    #1 rx_clear = 1'b0;
  endtask

  task automatic check_frame(input string name, input logic [7:0] d, input logic pe,
                             input logic fe, input logic ov);
    @(negedge clk);
    $display("frame %s: data=%02h rdy=%0b pe=%0b fe=%0b ov=%0b", name, rx_data,
             rx_ready, parity_err, frame_err, overrun);
    check8({name, ".data"}, rx_data, d);
    check1({name, ".ready"}, rx_ready, 1'b1);
    check1({name, ".parity_err"}, parity_err, pe);
    check1({name, ".frame_err"}, frame_err, fe);
    check1({name, ".overrun"}, overrun, ov);
  endtask

  task automatic check_idle_flags(input string name);
    check1({name, ".ready"}, rx_ready, 1'b0);
    check1({name, ".parity_err"}, parity_err, 1'b0);
    check1({name, ".frame_err"}, frame_err, 1'b0);
    check1({name, ".overrun"}, overrun, 1'b0);
    check1({name, ".busy"}, rx_busy, 1'b0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ready_m, ov_m;
    logic [7:0] d;
    logic       p, s, clr;

    tbl[0] = '{8'h08, 1'b0, 1'b1, 1'b1, 8'h08, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{8'h55, 1'b1, 1'b1, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{8'h0C, 1'b0, 1'b1, 1'b1, 8'h0C, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{8'h08, 1'b1, 1'b1, 1'b0, 8'h08, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{8'h80, 1'b0, 1'b1, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1};

    rst = 1'b0; rx = 1'b1; rx_clear = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check8("reset.data", rx_data, 8'h00);
    check_idle_flags("reset");
    rst = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_idle_flags("after_reset");

    // First frame with exact busy / ready timing relative to detection cycle.
    fork
      send_frame(8'h0C, 1'b0, 1'b1);
      begin
        @(posedge clk);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check1("timing.busy_at_D", rx_busy, 1'b0);
        @(posedge clk); @(negedge clk);
        check1("timing.busy_at_D1", rx_busy, 1'b1);
        repeat (4559 - 3) @(posedge clk);
        @(negedge clk);
        check1("timing.ready_at_D4557", rx_ready, 1'b0);
        check1("timing.busy_at_D4557", rx_busy, 1'b1);
        @(posedge clk); @(negedge clk);
        check1("timing.ready_at_D4558", rx_ready, 1'b1);
        check1("timing.busy_at_D4558", rx_busy, 1'b0);
        check8("timing.data_at_D4558", rx_data, 8'h0C);
      end
    join
    check_frame("first_0C", 8'h0C, 1'b0, 1'b0, 1'b0);

    // Table of frames.
    for (int i = 0; i < 5; i++) begin
      if (tbl[i].clr) begin
        pulse_clear();
        @(negedge clk);
        check1($sformatf("tbl%0d.cleared_ready", i), rx_ready, 1'b0);
        check1($sformatf("tbl%0d.cleared_ov", i), overrun, 1'b0);
      end
      send_frame(tbl[i].data, tbl[i].par, tbl[i].stop);
      check_frame($sformatf("tbl%0d", i), tbl[i].exp_data, tbl[i].exp_pe,
                  tbl[i].exp_fe, tbl[i].exp_ov);
    end

    // Acknowledge in the commit cycle: new byte held, overrun dropped.
    fork
      send_frame(8'h3C, 1'b0, 1'b1);
      begin
        @(posedge clk);
        repeat (4559) @(posedge clk);
        #1 rx_clear = 1'b1;
        @(posedge clk);
        #1 rx_clear = 1'b0;
        @(negedge clk);
        check1("simul.ready", rx_ready, 1'b1);
        check1("simul.overrun", overrun, 1'b0);
        check8("simul.data", rx_data, 8'h3C);
        @(posedge clk); @(negedge clk);
        check1("simul.ready_next", rx_ready, 1'b1);
      end
    join
    $display("frame simul_3C: data=%02h rdy=%0b ov=%0b", rx_data, rx_ready, overrun);

    // Reset during data bit 3 of an interrupted frame.
    fork
      send_frame(8'hF8, 1'b1, 1'b1);
      begin
        @(posedge clk);
        repeat (4 * CPB + 200) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check8("midrst.data", rx_data, 8'h00);
        check_idle_flags("midrst");
        #40 rst = 1'b1;
      end
    join
    @(negedge clk);
    check1("midrst.no_byte", rx_ready, 1'b0);
    check1("midrst.busy_after", rx_busy, 1'b0);
    send_frame(8'h0C, 1'b0, 1'b1);
    check_frame("after_midrst_0C", 8'h0C, 1'b0, 1'b0, 1'b0);

    // Stop bit low, then line held low: BREAK, no retrigger.
    pulse_clear();
    send_bits(8'hAA, 1'b0, 1'b0);
    check_frame("break_AA", 8'hAA, 1'b0, 1'b1, 1'b0);
    check1("break.busy", rx_busy, 1'b1);
    repeat (2 * CPB) @(posedge clk);
    @(negedge clk);
    check1("break.busy_held", rx_busy, 1'b1);
    @(posedge clk);
    #1 rx = 1'b1;
    pulse_clear();
    repeat (20) @(posedge clk);
    @(negedge clk);
    check_idle_flags("break_exit");

    // Glitch shorter than half a bit.
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (50) @(posedge clk);
    @(negedge clk);
    check1("glitch.busy", rx_busy, 1'b1);
    repeat (50) @(posedge clk);
    #1 rx = 1'b1;
    repeat (300) @(posedge clk);
    @(negedge clk);
    check_idle_flags("glitch");
    $display("glitch: busy=%0b rdy=%0b", rx_busy, rx_ready);

    // Randomized frames against a byte-level model.
    ready_m = 1'b0;
    ov_m    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d   = 8'($urandom_range(0, 255));
      p   = (^d) ^ ($urandom_range(0, 3) == 0);
      s   = ($urandom_range(0, 3) != 0);
      clr = 1'($urandom_range(0, 1));
      if (clr) begin
        pulse_clear();
        ready_m = 1'b0;
        ov_m    = 1'b0;
      end
      send_frame(d, p, s);
      ov_m    = ov_m | ready_m;
      ready_m = 1'b1;
      check_frame($sformatf("rand%0d", i), d, ($countones({d, p}) % 2) == 1, ~s, ov_m);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
